// File: rtl/m_mem_ctrl_if.sv
// Core-side request, write-beat and read-beat channels of the memory bus master.
// The controller takes the slave modport; the requesting core takes master.
interface m_mem_ctrl_if #(
  parameter int unsigned WORD = 16,
  parameter int unsigned AW   = 11
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [3:0]      req_len;
  logic [WORD-1:0] wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [WORD-1:0] rd_data;
  logic            rd_valid;
  logic            done;
  logic            busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, done, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, done, busy
  );
endinterface

// File: rtl/m_mem_ctrl.sv
// Burst bus master for the single-port word memory: sequences addresses and beats,
// owns the write side of the shared data bus and inserts read/write turnaround.
module m_mem_ctrl #(
  parameter int unsigned WORD = 16,
  parameter int unsigned AW   = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  m_mem_ctrl_if.slave        core,
  output logic               o_mem_we,
  output logic               o_mem_re,
  output logic [AW-1:0]      o_mem_addr,
  inout  wire  [WORD-1:0]    io_mem_dq
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWcommit,
    StRd,
    StTurn
  } state_e;

  state_e          r_state,    w_state_nxt;
  logic [AW-1:0]   r_addr,     w_addr_nxt;
  logic [4:0]      r_beats,    w_beats_nxt;
  logic            r_mem_we,   w_mem_we_nxt;
  logic            r_mem_re,   w_mem_re_nxt;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [WORD-1:0] r_wdata,    w_wdata_nxt;
  logic [WORD-1:0] r_rd_data,  w_rd_data_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
  logic            r_done,     w_done_nxt;

  // r_addr holds the address of the next beat to issue; r_beats the beats still owed.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_beats_nxt    = r_beats;
    w_mem_we_nxt   = 1'b0;
    w_mem_re_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_wdata_nxt    = r_wdata;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (core.req_valid) begin
          w_addr_nxt  = core.req_addr;
          w_beats_nxt = {1'b0, core.req_len} + 5'd1;
          if (core.req_write) begin
            w_state_nxt = StWr;
          end else begin
            w_state_nxt    = StRd;
            w_mem_re_nxt   = 1'b1;
            w_mem_addr_nxt = core.req_addr;
          end
        end
      end
      StWr: begin
        if (core.wr_valid) begin
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = r_addr;
          w_wdata_nxt    = core.wr_data;
          w_addr_nxt     = r_addr + AW'(1);
          w_beats_nxt    = r_beats - 5'd1;
          if (r_beats == 5'd1) begin
            w_state_nxt = StWcommit;
          end
        end
      end
      StWcommit: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      StRd: begin
        w_rd_data_nxt  = io_mem_dq;
        w_rd_valid_nxt = 1'b1;
        w_beats_nxt    = r_beats - 5'd1;
        if (r_beats == 5'd1) begin
          // Last sample: drop mem_re now so TURN leaves the bus idle for a cycle.
          w_done_nxt  = 1'b1;
          w_state_nxt = StTurn;
        end else begin
          w_mem_re_nxt   = 1'b1;
          w_mem_addr_nxt = r_addr + AW'(1);
          w_addr_nxt     = r_addr + AW'(1);
        end
      end
      StTurn: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_beats    <= '0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_beats    <= w_beats_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_re   <= w_mem_re_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign core.req_ready = (r_state == StIdle);
  assign core.wr_ready  = (r_state == StWr);
  assign core.busy      = (r_state != StIdle);
  assign core.rd_data   = r_rd_data;
  assign core.rd_valid  = r_rd_valid;
  assign core.done      = r_done;

  assign o_mem_we   = r_mem_we;
  assign o_mem_re   = r_mem_re;
  assign o_mem_addr = r_mem_addr;
  assign io_mem_dq  = r_mem_we ? r_wdata : {WORD{1'bz}};

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Bench for m_mem_ctrl: behavioural async-read memory on the shared bus, scoreboards
// for bus writes and read beats, and cycle-exact handshake checks per burst.
module tb_m_mem_ctrl;
  logic        clk;
  logic        rst;
  logic        mem_init;
  logic        mem_we;
  logic        mem_re;
  logic [10:0] mem_addr;
  wire  [15:0] mem_dq;

  logic [15:0] mem     [0:2047];
  logic [15:0] exp_mem [0:2047];
  logic [15:0] rd_q [$];
  logic [26:0] wq   [$];
  int          n_vec;
  int          n_err;
  logic        prev_we;
  logic        prev_re;

  m_mem_ctrl_if #(.WORD(16), .AW(11)) core_if ();

  m_mem_ctrl #(.WORD(16), .AW(11)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .core       (core_if),
    .o_mem_we   (mem_we),
    .o_mem_re   (mem_re),
    .o_mem_addr (mem_addr),
    .io_mem_dq  (mem_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37) ^ 16'h5A00;
  endfunction

  // Memory model: combinational read while mem_re, write at the clock edge.
  assign mem_dq = mem_re ? mem[mem_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_dq;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bus monitor: write and read scoreboards plus strobe exclusion and turnaround.
  always @(negedge clk) begin
    check_eq("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    check_eq("rd_after_wr_gap", 32'(prev_we & mem_re), 32'd0);
    check_eq("wr_after_rd_gap", 32'(prev_re & mem_we), 32'd0);
    prev_we = mem_we;
    prev_re = mem_re;
    if (mem_we) begin
      check_eq("wq_avail", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        logic [26:0] e;
        e = wq.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(e[26:16]));
        check_eq("wr_bus_data", 32'(mem_dq), 32'(e[15:0]));
      end
    end
    if (core_if.rd_valid) begin
      check_eq("rd_q_avail", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) check_eq("rd_data", 32'(core_if.rd_data), 32'(rd_q.pop_front()));
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic w, input logic [10:0] a, input logic [3:0] l);
    logic rdy;
    rdy = 1'b0;
    core_if.req_valid = 1'b1;
    core_if.req_write = w;
    core_if.req_addr  = a;
    core_if.req_len   = l;
    for (int k = 0; k < 20; k++) begin
      rdy = core_if.req_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check_eq("accept", 32'(rdy), 32'd1);
    check_eq("busy_after_accept", 32'(core_if.busy), 32'd1);
    check_eq("ready_low_after_accept", 32'(core_if.req_ready), 32'd0);
  endtask

  // Returns at the done/IDLE negedge.
  task automatic do_write(input logic [10:0] a, input logic [3:0] l, input logic [15:0] base,
                          input logic [15:0] step, input logic [7:0] gaps);
    int n;
    int b;
    int cyc;
    logic v;
    logic [10:0] ai;
    logic [15:0] d;
    n = int'(l) + 1;
    b = 0;
    cyc = 0;
    issue(1'b1, a, l);
    while (b < n && cyc < 64) begin
      v = (cyc < 8) ? gaps[cyc] : 1'b1;
      ai = a + 11'(b);
      d = base + 16'(b) * step;
      check_eq("wr_ready", 32'(core_if.wr_ready), 32'd1);
      core_if.wr_valid = v;
      core_if.wr_data  = d;
      if (v) begin
        wq.push_back({ai, d});
        exp_mem[ai] = d;
        b++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    core_if.wr_valid = 1'b0;
    check_eq("wr_beats_accepted", 32'(b), 32'(n));
    check_eq("wcommit_we", 32'(mem_we), 32'd1);
    check_eq("wcommit_no_done", 32'(core_if.done), 32'd0);
    @(negedge clk);
    check_eq("wr_done", 32'(core_if.done), 32'd1);
    check_eq("wr_done_ready", 32'(core_if.req_ready), 32'd1);
    check_eq("wr_done_we_low", 32'(mem_we), 32'd0);
    check_eq("wr_queue_drained", 32'(wq.size()), 32'd0);
  endtask

  // Returns at the TURN negedge (last rd_valid with done).
  task automatic do_read(input logic [10:0] a, input logic [3:0] l);
    int n;
    int re_cnt;
    n = int'(l) + 1;
    for (int i = 0; i < n; i++) rd_q.push_back(exp_mem[a + 11'(i)]);
    issue(1'b0, a, l);
    re_cnt = int'(mem_re);
    check_eq("rd_first_addr", 32'(mem_addr), 32'(a));
    check_eq("rd_latency_no_valid", 32'(core_if.rd_valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      re_cnt += int'(mem_re);
      check_eq("rd_valid_run", 32'(core_if.rd_valid), 32'd1);
      check_eq("rd_done_last", 32'(core_if.done), 32'(i == n - 1));
    end
    check_eq("rd_re_cycles", 32'(re_cnt), 32'(n));
    check_eq("turn_re_low", 32'(mem_re), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(core_if.req_ready), 32'd1);
    check_eq({tag, "_wr_ready"}, 32'(core_if.wr_ready), 32'd0);
    check_eq({tag, "_rd_valid"}, 32'(core_if.rd_valid), 32'd0);
    check_eq({tag, "_done"}, 32'(core_if.done), 32'd0);
    check_eq({tag, "_busy"}, 32'(core_if.busy), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_re"}, 32'(mem_re), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_rd_data"}, 32'(core_if.rd_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_we = 1'b0;
    prev_re = 1'b0;
    rst = 1'b1;
    mem_init = 1'b1;
    core_if.req_valid = 1'b0;
    core_if.req_write = 1'b0;
    core_if.req_addr  = '0;
    core_if.req_len   = '0;
    core_if.wr_valid  = 1'b0;
    core_if.wr_data   = '0;
    for (int i = 0; i < 2048; i++) exp_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    // Single write then read.
    do_write(11'h005, 4'd0, 16'hBEEF, 16'h0000, 8'hFF);
    do_read(11'h005, 4'd0);
    @(negedge clk);

    // 4-beat burst then readback, read issued in the done cycle.
    do_write(11'h010, 4'd3, 16'h1111, 16'h1111, 8'hFF);
    do_read(11'h010, 4'd3);
    @(negedge clk);

    // Address wrap at the top of memory.
    do_write(11'h7FE, 4'd3, 16'hA001, 16'h0001, 8'hFF);
    do_read(11'h7FE, 4'd3);
    @(negedge clk);

    // Stalled write beats: wr_valid 1,0,0,1,0,1.
    do_write(11'h020, 4'd2, 16'h0C10, 16'h0101, 8'b1110_1001);
    do_read(11'h020, 4'd2);

    // Read immediately followed by a write request raised in TURN.
    do_read(11'h010, 4'd3);
    do_write(11'h030, 4'd1, 16'h7E00, 16'h0011, 8'hFF);
    do_read(11'h030, 4'd1);
    @(negedge clk);

    // 16-beat read across untouched memory (req_len = F).
    do_read(11'h400, 4'hF);
    @(negedge clk);

    // Reset after beat 2 of an 8-beat write.
    issue(1'b1, 11'h100, 4'd7);
    core_if.wr_valid = 1'b1;
    core_if.wr_data  = 16'hC000;
    wq.push_back({11'h100, 16'hC000});
    exp_mem[11'h100] = 16'hC000;
    @(posedge clk);
    @(negedge clk);
    core_if.wr_data = 16'hC001;
    wq.push_back({11'h101, 16'hC001});
    exp_mem[11'h101] = 16'hC001;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    core_if.wr_data = 16'hC002;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    core_if.wr_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("midreset_no_done", 32'(core_if.done), 32'd0);
      check_eq("midreset_idle", 32'(core_if.busy), 32'd0);
    end
    do_read(11'h100, 4'd7);

    repeat (3) @(negedge clk);
    check_eq("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check_eq("wq_drained", 32'(wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/m_mem_ctrl.md
# m_mem_ctrl

Bus master for the single-port word memory (`m_mem`) in the MPU datapath. It accepts burst read and write requests from the core over a valid/ready handshake and drives the memory's `we`/`re`/`addr` strobes. It owns the write side of the shared bidirectional data bus and captures read data returned on it. It also sequences addresses, counts beats, and inserts bus turnaround so it never drives the bus while a read is in progress.

## Interface
- `WORD`, 16: data width in bits.
- `AW`, 11: memory address width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  AW  start word address.
- `req_len`  in  4  beats minus one (1..16 beats).
- `wr_data`  in  WORD  write beat data.
- `wr_valid`  in  1  write beat offered.
- `wr_ready`  out  1  write beat accepted this cycle; high in WR state.
- `rd_data`  out  WORD  registered read beat.
- `rd_valid`  out  1  one-cycle pulse per read beat; no backpressure.
- `done`  out  1  one-cycle pulse at burst completion.
- `busy`  out  1  high whenever state is not IDLE.
- `mem_we`  out  1  memory write strobe, registered.
- `mem_re`  out  1  memory read enable, registered.
- `mem_addr`  out  AW  memory address, registered.
- `mem_dq`  inout  WORD  shared data bus; driven by this block only while `mem_we`=1, otherwise high-Z.

## Operation
- States: IDLE, WR, WCOMMIT, RD, TURN.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch addr, `beats`=`req_len`+1 and direction.
  - Go to WR if `req_write`=1, else RD.
- WR:
  - `wr_ready`=1 (combinational on state).
  - Each `wr_valid`&`wr_ready` edge: `mem_we`<=1, `mem_addr`<=addr, bus data<=`wr_data`; addr+=1; beats-=1.
  - No beat that edge: `mem_we`<=0.
  - Last beat accepted: go to WCOMMIT.
- WCOMMIT:
  - `mem_we` is high for the last beat; the memory commits at this edge.
  - Next edge: `mem_we`<=0, `done`<=1, go to IDLE.
- RD:
  - `mem_re`=1 and `mem_addr`=addr every cycle.
  - Each edge: `rd_data`<=`mem_dq`, `rd_valid`<=1, addr+=1, beats-=1.
  - After the last sample, go to TURN.
- TURN:
  - `mem_re`=0 and the bus is not driven.
  - `rd_valid` and `done` are high for this one cycle (the last beat's pulse).
  - Next edge: go to IDLE.
- Address arithmetic is modulo 2^AW: 2047+1 wraps to 0 with no error flag.
- `req_len` is not saturated; 4'hF means 16 beats.
- `req_valid` while not in IDLE is ignored; the request is not latched.
- Invariant: `mem_we` and `mem_re` are never high in the same cycle. The bus is driven only when `mem_we`=1.
- Read-to-write: TURN guarantees at least one cycle with `mem_re`=0 before any `mem_we`.
- Write-to-read: IDLE guarantees at least one cycle with `mem_we`=0 before `mem_re`.
- Reset:
  - Takes effect at the next edge from any state: go to IDLE.
  - The in-flight burst is dropped, no `done` is issued, and memory content already committed is kept.

## Timing
- Reset values:
  - `req_ready`=1 (IDLE); `wr_ready`=0, `rd_valid`=0, `done`=0, `busy`=0.
  - `mem_we`=0, `mem_re`=0, `mem_addr`=0, `rd_data`=0, bus high-Z.
- Read latency:
  - Request accepted at edge E0, so `mem_re` is high after E0.
  - First `rd_valid` is in the cycle after E1.
  - An N-beat read gives N consecutive `rd_valid` cycles, the last coinciding with `done`.
- Write:
  - Beat accepted at edge Ek; the memory stores it at Ek+1.
  - `done` is high in the cycle after the commit edge of the last beat, and `req_ready`=1 in that same cycle.
- Back-to-back: a new request may be accepted in the first IDLE cycle, including the cycle in which `done` is high.
- Minimum cycles from accept to accept:
  - N-beat read: N+2.
  - N-beat write with `wr_valid` held high: N+2.

## Test plan
- Single write then read:
  - Write 0xBEEF to 0x005, then read 0x005.
  - Expect `rd_data`=0xBEEF with `rd_valid` two cycles after the read is accepted, and `done` pulses once per burst.
- 4-beat write burst then read burst at 0x010:
  - Write 0x1111..0x4444, then read them back.
  - Expect `rd_valid` on 4 consecutive cycles in address order, and `mem_re` high for exactly 4 cycles.
- Wrap-around:
  - Write burst `req_len`=3 at 0x7FE.
  - Expect `mem_addr` sequence 0x7FE, 0x7FF, 0x000, 0x001; readback matches.
- Write stall:
  - Gaps in `wr_valid` (pattern 1,0,0,1,0,1) during a 3-beat write.
  - Expect `mem_we` high only on cycles following accepted beats, addresses contiguous, and `done` after the third commit.
- Turnaround:
  - Read burst immediately followed by a write request.
  - Expect `mem_we`&`mem_re` never both 1, at least one cycle with both 0 between them, and the bus high-Z whenever `mem_we`=0.
- Reset mid-burst:
  - Assert `rst` after beat 2 of an 8-beat write.
  - Expect IDLE next cycle, all outputs at reset values, no `done`, words 0-1 committed and words 2-7 unchanged.
